// File: rtl/frame_sched_pkg.sv
// Shared types and defaults for the per-frame update scheduler.
// Optional feature macro: FRAME_SCHED_SYNC_EN (2-flop input synchronizers).
package frame_sched_pkg;

    localparam logic        DEF_VS_ACTIVE   = 1'b0;
    localparam int unsigned DEF_UPDATE_DIV  = 1;
    localparam int unsigned DEF_TIMEOUT     = 1024;
    localparam int unsigned DEF_FRAME_CNT_W = 16;
    localparam int unsigned DIV_W           = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ME      = 3'd1,
        ST_BULLET  = 3'd2,
        ST_ENEMY   = 3'd3,
        ST_COLLIDE = 3'd4
    } phase_e;

    // One start strobe per update engine
    typedef struct packed {
        logic me;
        logic bullet;
        logic enemy;
        logic collide;
    } phase_strb_t;

    // Fixed engine order; anything unexpected falls back to IDLE
    function automatic phase_e next_phase(input phase_e s);
        phase_e n;
        case (s)
            ST_IDLE:   n = ST_ME;
            ST_ME:     n = ST_BULLET;
            ST_BULLET: n = ST_ENEMY;
            ST_ENEMY:  n = ST_COLLIDE;
            default:   n = ST_IDLE;
        endcase
        return n;
    endfunction

    // Start strobe that belongs to a phase state
    function automatic phase_strb_t phase_strobe(input phase_e s);
        phase_strb_t p;
        p = '0;
        case (s)
            ST_ME:      p.me      = 1'b1;
            ST_BULLET:  p.bullet  = 1'b1;
            ST_ENEMY:   p.enemy   = 1'b1;
            ST_COLLIDE: p.collide = 1'b1;
            default:    p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/frame_sched_tick.sv
// Frame tick generator: optional input synchronizer, v_sync trailing-edge
// detect, frame counter and update divider.
// Optional feature macro: FRAME_SCHED_SYNC_EN.
module frame_tick_gen
    import frame_sched_pkg::*;
#(
    parameter logic        VS_ACTIVE   = DEF_VS_ACTIVE,
    parameter int unsigned UPDATE_DIV  = DEF_UPDATE_DIV,
    parameter int unsigned FRAME_CNT_W = DEF_FRAME_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   v_sync_i,
    input  logic                   pause_i,
    output logic                   tick_c,
    output logic                   update_tick_c,
    output logic                   pause_c,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(UPDATE_DIV - 1);

    logic             vs_in;
    logic             vs_q;
    logic [DIV_W-1:0] div_cnt;

`ifdef FRAME_SCHED_SYNC_EN
    logic [1:0] vs_sync;
    logic [1:0] pause_sync;

    // Two-flop synchronizers so v_sync/pause may come from another clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_sync    <= {2{~VS_ACTIVE}};
            pause_sync <= 2'b00;
        end else begin
            vs_sync    <= {vs_sync[0], v_sync_i};
            pause_sync <= {pause_sync[0], pause_i};
        end
    end

    assign vs_in   = vs_sync[1];
    assign pause_c = pause_sync[1];
`else
    assign vs_in   = v_sync_i;
    assign pause_c = pause_i;
`endif

    // Tick on the trailing edge of the sync pulse
    assign tick_c        = (vs_q == VS_ACTIVE) && (vs_in != VS_ACTIVE);
    assign update_tick_c = tick_c && (div_cnt == DIV_LAST);

    // Sync history, frame counter and divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q      <= ~VS_ACTIVE;
            div_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            vs_q <= vs_in;
            if (tick_c) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/frame_sched.sv
// Per-frame update scheduler: after each v_sync pulse, sequences the me,
// bullet, enemy and collision engines with a start/done handshake.
// Optional feature macro: FRAME_SCHED_SYNC_EN (synchronizes v_sync_i/pause_i).
module frame_sched
    import frame_sched_pkg::*;
#(
    parameter logic        VS_ACTIVE   = DEF_VS_ACTIVE,
    parameter int unsigned UPDATE_DIV  = DEF_UPDATE_DIV,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned FRAME_CNT_W = DEF_FRAME_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   v_sync_i,
    input  logic                   pause_i,
    input  logic                   clr_err_i,
    input  logic                   me_done_i,
    input  logic                   bullet_done_i,
    input  logic                   enemy_done_i,
    input  logic                   collide_done_i,
    output logic                   me_start_o,
    output logic                   bullet_start_o,
    output logic                   enemy_start_o,
    output logic                   collide_start_o,
    output logic                   busy_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o,
    output logic                   overrun_o,
    output logic                   timeout_o
);

    localparam int unsigned     TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic tick_c;
    logic update_tick_c;
    logic pause_c;

    phase_e          state_q, state_d;
    phase_strb_t     start_q, start_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            overrun_d;
    logic            timeout_d;
    logic            phase_done;
    logic            advance;

    frame_tick_gen #(
        .VS_ACTIVE  (VS_ACTIVE),
        .UPDATE_DIV (UPDATE_DIV),
        .FRAME_CNT_W(FRAME_CNT_W)
    ) u_tick (
        .clk          (clk),
        .rst          (rst),
        .v_sync_i     (v_sync_i),
        .pause_i      (pause_i),
        .tick_c       (tick_c),
        .update_tick_c(update_tick_c),
        .pause_c      (pause_c),
        .frame_cnt    (frame_cnt_o)
    );

    // Next-state, start strobes, phase timeout and sticky error flags
    always_comb begin
        state_d    = state_q;
        start_d    = '0;
        to_cnt_d   = to_cnt_q;
        overrun_d  = overrun_o;
        timeout_d  = timeout_o;
        phase_done = 1'b0;
        advance    = 1'b0;

        case (state_q)
            ST_ME:      phase_done = me_done_i;
            ST_BULLET:  phase_done = bullet_done_i;
            ST_ENEMY:   phase_done = enemy_done_i;
            ST_COLLIDE: phase_done = collide_done_i;
            default:    phase_done = 1'b0;
        endcase

        if (clr_err_i) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
        if (tick_c && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        if (state_q == ST_IDLE) begin
            advance = update_tick_c && !pause_c;
        end else if (start_q == '0) begin
            // start_q is high only in a phase's first cycle; done is ignored there
            if (phase_done) begin
                advance = 1'b1;
            end else if (to_cnt_q == TO_LAST) begin
                timeout_d = 1'b1;
                advance   = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end

        if (advance) begin
            state_d  = next_phase(state_q);
            start_d  = phase_strobe(state_d);
            to_cnt_d = '0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            start_q   <= '0;
            to_cnt_q  <= '0;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            to_cnt_q  <= to_cnt_d;
            busy_o    <= (state_d != ST_IDLE);
            overrun_o <= overrun_d;
            timeout_o <= timeout_d;
        end
    end

    assign me_start_o      = start_q.me;
    assign bullet_start_o  = start_q.bullet;
    assign enemy_start_o   = start_q.enemy;
    assign collide_start_o = start_q.collide;

endmodule

// File: tb/tb_frame_sched.sv
// Self-checking bench for frame_sched: scoreboard of expected start pulses.
module tb_frame_sched;

    localparam int unsigned TO = 8;
`ifdef FRAME_SCHED_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    typedef struct {
        logic [3:0] strb;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        v_sync, pause, clr_err;
    logic [3:0]  dn;
    logic        me_start, bullet_start, enemy_start, collide_start;
    logic        busy, overrun, timeout;
    logic [15:0] frame_cnt;

    logic        vs3;
    logic        me3, bullet3, enemy3, collide3, busy3, overrun3, timeout3;
    logic [15:0] frame_cnt3;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   busy_cnt = 0;
    int   cd[4];
    int   dly[4];
    exp_t exp_q[$];
    int   exp3_q[$];

    frame_sched #(.VS_ACTIVE(1'b0), .UPDATE_DIV(1), .TIMEOUT(TO), .FRAME_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .v_sync_i(v_sync), .pause_i(pause), .clr_err_i(clr_err),
        .me_done_i(dn[0]), .bullet_done_i(dn[1]), .enemy_done_i(dn[2]), .collide_done_i(dn[3]),
        .me_start_o(me_start), .bullet_start_o(bullet_start), .enemy_start_o(enemy_start),
        .collide_start_o(collide_start), .busy_o(busy), .frame_cnt_o(frame_cnt),
        .overrun_o(overrun), .timeout_o(timeout)
    );

    frame_sched #(.VS_ACTIVE(1'b0), .UPDATE_DIV(3), .TIMEOUT(TO), .FRAME_CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .v_sync_i(vs3), .pause_i(1'b0), .clr_err_i(1'b0),
        .me_done_i(1'b1), .bullet_done_i(1'b1), .enemy_done_i(1'b1), .collide_done_i(1'b1),
        .me_start_o(me3), .bullet_start_o(bullet3), .enemy_start_o(enemy3),
        .collide_start_o(collide3), .busy_o(busy3), .frame_cnt_o(frame_cnt3),
        .overrun_o(overrun3), .timeout_o(timeout3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Two-cycle low pulse on v_sync; returns the cycle of the internal tick
    task automatic pulse(output int t);
        v_sync = 1'b0;
        step(2);
        v_sync = 1'b1;
        t = cyc + SL;
    endtask

    task automatic push(input logic [3:0] s, input int c);
        exp_t e;
        e.strb = s;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic push_normal(input int t);
        push(4'b1000, t + 1);
        push(4'b0100, t + 5);
        push(4'b0010, t + 9);
        push(4'b0001, t + 13);
    endtask

    // Done responder: raise done_i dly cycles after the start pulse
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            dn[i] = 1'b0;
            if (cd[i] > 0) begin
                cd[i]--;
                if (cd[i] == 0) dn[i] = 1'b1;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [3:0] s;
        exp_t       e;
        int         c3;
        s = {me_start, bullet_start, enemy_start, collide_start};
        if (busy) busy_cnt++;
        if (s != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (s[3-i] && dly[i] > 0) cd[i] = dly[i];
            end
            if (exp_q.size() == 0) begin
                check("unexpected_start", {28'b0, s}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("start_phase", {28'b0, s}, {28'b0, e.strb});
                check("start_cycle", cyc, e.cyc);
            end
        end
        if (me3) begin
            if (exp3_q.size() == 0) begin
                check("div_extra_me", {31'b0, me3}, 32'd0);
            end else begin
                c3 = exp3_q.pop_front();
                check("div_me_cycle", cyc, c3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        rst     = 1'b1;
        v_sync  = 1'b1;
        vs3     = 1'b1;
        pause   = 1'b0;
        clr_err = 1'b0;
        dn      = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cd[i]  = 0;
            dly[i] = 3;
        end

        // Reset state
        step(3);
        check("rst_starts", {28'b0, me_start, bullet_start, enemy_start, collide_start}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        check("rst_overrun", {31'b0, overrun}, 32'd0);
        check("rst_timeout", {31'b0, timeout}, 32'd0);
        rst = 1'b0;
        step(3);

        // Basic sequence, done 3 cycles after each start
        busy_cnt = 0;
        pulse(t);
        push_normal(t);
        step(22);
        check("basic_drained", exp_q.size(), 32'd0);
        check("basic_busy_cycles", busy_cnt, 32'd16);
        check("basic_frame_cnt", {16'b0, frame_cnt}, 32'd1);
        check("basic_overrun", {31'b0, overrun}, 32'd0);
        check("basic_timeout", {31'b0, timeout}, 32'd0);

        // Enemy never finishes: collide starts 9 cycles after enemy
        dly[2] = 0;
        pulse(t);
        push(4'b1000, t + 1);
        push(4'b0100, t + 5);
        push(4'b0010, t + 9);
        push(4'b0001, t + 18);
        step(30);
        dly[2] = 3;
        check("to_drained", exp_q.size(), 32'd0);
        check("to_flag_set", {31'b0, timeout}, 32'd1);
        check("to_frame_cnt", {16'b0, frame_cnt}, 32'd2);
        step(3);
        check("to_flag_sticky", {31'b0, timeout}, 32'd1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("to_flag_cleared", {31'b0, timeout}, 32'd0);

        // Second tick while in BULLET
        pulse(t);
        push_normal(t);
        step(4);
        v_sync = 1'b0;
        step(2);
        v_sync = 1'b1;
        step(20);
        check("ovr_drained", exp_q.size(), 32'd0);
        check("ovr_flag_set", {31'b0, overrun}, 32'd1);
        check("ovr_frame_cnt", {16'b0, frame_cnt}, 32'd4);
        check("ovr_no_timeout", {31'b0, timeout}, 32'd0);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("ovr_flag_cleared", {31'b0, overrun}, 32'd0);

        // Paused over two ticks, then released
        pause = 1'b1;
        step(3);
        busy_cnt = 0;
        pulse(t);
        step(12);
        pulse(t);
        step(12);
        check("pause_no_busy", busy_cnt, 32'd0);
        check("pause_frame_cnt", {16'b0, frame_cnt}, 32'd6);
        pause = 1'b0;
        step(3);
        pulse(t);
        push_normal(t);
        step(22);
        check("unpause_drained", exp_q.size(), 32'd0);
        check("unpause_frame_cnt", {16'b0, frame_cnt}, 32'd7);

        // Reset during ENEMY
        pulse(t);
        push(4'b1000, t + 1);
        push(4'b0100, t + 5);
        push(4'b0010, t + 9);
        step(10 + SL);
        rst = 1'b1;
        #2;
        check("mid_rst_drained", exp_q.size(), 32'd0);
        check("mid_rst_starts", {28'b0, me_start, bullet_start, enemy_start, collide_start}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        check("mid_rst_flags", {30'b0, overrun, timeout}, 32'd0);
        step(1);
        rst = 1'b0;
        step(6);
        pulse(t);
        push_normal(t);
        step(22);
        check("post_rst_drained", exp_q.size(), 32'd0);
        check("post_rst_frame_cnt", {16'b0, frame_cnt}, 32'd1);

        // UPDATE_DIV = 3: sequences only on ticks 3 and 6
        for (int k = 1; k <= 6; k++) begin
            vs3 = 1'b0;
            step(2);
            vs3 = 1'b1;
            if (k % 3 == 0) exp3_q.push_back(cyc + SL + 1);
            step(12);
        end
        check("div_drained", exp3_q.size(), 32'd0);
        check("div_frame_cnt", {16'b0, frame_cnt3}, 32'd6);
        check("div_overrun", {31'b0, overrun3}, 32'd0);
        check("main_idle_at_end", {31'b0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frame_sched.md
Name: frame_sched

Overview:
- Per-frame update scheduler for the game-logic side of the display pipeline.
- Detects the end of each vertical sync pulse and sequences the object-update engines in a fixed order: player plane ("me"), bullets, enemies, collision.
- Uses a start/done handshake so that sprite positions and alpha data feeding the pixel mux are stable before active video.
- Sits beside the VGA driver; its strobes drive the me/bullet/enemy/collision update blocks.

Parameters:
- VS_ACTIVE, 1'b0, level of v_sync_i while the sync pulse is active.
- UPDATE_DIV, 1, run the update sequence every UPDATE_DIV-th frame (legal range 1..255).
- TIMEOUT, 1024, maximum cycles to wait for a phase's done_i before forcing advance.
- FRAME_CNT_W, 16, width of frame_cnt_o.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- v_sync_i  in  1  vertical sync, synchronous to clk
- pause_i  in  1  when high, frame ticks are counted but no update sequence starts
- clr_err_i  in  1  clears the sticky error flags
- me_done_i  in  1  me update finished (single-cycle pulse or level)
- bullet_done_i  in  1  bullet update finished
- enemy_done_i  in  1  enemy update finished
- collide_done_i  in  1  collision check finished
- me_start_o  out  1  one-cycle start pulse
- bullet_start_o  out  1  one-cycle start pulse
- enemy_start_o  out  1  one-cycle start pulse
- collide_start_o  out  1  one-cycle start pulse
- busy_o  out  1  high from the first start pulse until return to IDLE
- frame_cnt_o  out  FRAME_CNT_W  count of frame ticks, wraps modulo 2^FRAME_CNT_W
- overrun_o  out  1  sticky: frame tick arrived while busy
- timeout_o  out  1  sticky: a phase hit TIMEOUT

Interface decision: single clock clk; reset rst is asynchronous, active-high.

Behaviour:
- Reset: all outputs are 0; the FSM is in IDLE; the v_sync history register is set to the inactive level; the divider counter is 0.
- Frame tick: asserted for one cycle when the registered v_sync is active and v_sync_i is inactive (trailing edge). frame_cnt_o increments in the same cycle.
- Divider: counts ticks from 0 to UPDATE_DIV-1. A tick with count == UPDATE_DIV-1 is an "update tick"; the counter wraps to 0. With UPDATE_DIV = 1, every tick is an update tick.
- FSM states: IDLE, ME, BULLET, ENEMY, COLLIDE.
  - IDLE: on an update tick with pause_i = 0, go to ME. The divider still advances while paused.
  - Each phase state, on entry: the matching start_o is high exactly in the first cycle of the state; the timeout counter is loaded with 0.
  - Each phase state, every following cycle: if done_i is high, advance to the next state. A done_i coinciding with the start pulse is ignored. Otherwise, if the counter == TIMEOUT-1, set timeout_o and advance; else increment the counter.
  - COLLIDE advances to IDLE.
- Latency: tick at cycle t gives me_start_o at t+1. A phase whose done_i arrives at cycle d issues the next start_o at d+1.
- busy_o = (state != IDLE), registered with the state.
- Overrun: a tick while state != IDLE sets overrun_o. That tick does not restart the sequence; the in-flight sequence completes.
- clr_err_i clears both sticky flags. A same-cycle set wins over clear.
- pause_i rising mid-sequence does not abort; it only blocks new starts.
- Reset asserted mid-phase returns everything to reset values immediately; no done_i is awaited.

Optional Feature:
- Macro: FRAME_SCHED_SYNC_EN.
- Defined: v_sync_i and pause_i pass through a 2-flop synchronizer before use. Tick latency grows by 2 cycles (me_start_o at t+3 relative to the v_sync_i edge), so v_sync_i may come from clk_vga.
- Undefined: inputs are used directly, with the latency given above.

Decomposition:
- Shared package/header: phase state encodings (IDLE=0, ME=1, BULLET=2, ENEMY=3, COLLIDE=4, 3 bits), default TIMEOUT and UPDATE_DIV values, VS_ACTIVE default.
- One natural sub-module: frame_tick_gen (optional synchronizer, edge detect, frame counter, divider) producing tick and update_tick.

Test Plan:
- Reset, then v_sync_i pulses low for 2 cycles with done_i returned 3 cycles after each start -> me/bullet/enemy/collide starts spaced 4 cycles apart, busy_o high for 16 cycles, frame_cnt_o = 1.
- UPDATE_DIV=3, 6 frame ticks -> sequences start only on ticks 3 and 6; frame_cnt_o = 6.
- enemy_done_i never asserted, TIMEOUT=8 -> collide_start_o follows enemy_start_o by exactly 9 cycles; timeout_o = 1 until clr_err_i.
- Second tick while in BULLET -> overrun_o = 1; no extra me_start_o; sequence completes normally.
- pause_i = 1 over 2 ticks -> no start pulses, frame_cnt_o += 2; after release, the next update tick starts ME.
- rst pulsed during ENEMY -> all outputs 0 next cycle; the next tick restarts at ME.
